// File: rtl/kb_pkg.sv
// Shared scancode constants, parser state encoding and LED bit positions
// for the PS/2 keyboard lock controller.
package kb_pkg;

    localparam logic [7:0] SC_E0     = 8'hE0;
    localparam logic [7:0] SC_E1     = 8'hE1;
    localparam logic [7:0] SC_F0     = 8'hF0;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_NUM    = 8'h77;
    localparam logic [7:0] SC_SCROLL = 8'h7E;

    localparam int LED_SCROLL = 0;
    localparam int LED_NUM    = 1;
    localparam int LED_CAPS   = 2;

    // Bytes that follow E1 in the Pause sequence
    localparam logic [2:0] E1_SKIP_LEN = 3'd7;

    // Event entry layout: {code[7:0], ext, brk}
    localparam int EVT_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GOT_E0,
        ST_GOT_F0,
        ST_GOT_E0F0,
        ST_SKIP_E1
    } parse_state_t;

    // Keyboard status/response bytes that never start a key event
    function automatic logic is_filtered(input logic [7:0] code);
        case (code)
            8'h00, 8'hAA, 8'hEE, 8'hFA,
            8'hFC, 8'hFD, 8'hFE, 8'hFF: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] lock_mask(input logic [7:0] code);
        logic [2:0] m;
        m = 3'b000;
        case (code)
            SC_CAPS:   m[LED_CAPS]   = 1'b1;
            SC_NUM:    m[LED_NUM]    = 1'b1;
            SC_SCROLL: m[LED_SCROLL] = 1'b1;
            default:   m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/kb_event_fifo.sv
// Key event FIFO: power-of-two depth, simultaneous push/pop always succeeds,
// sticky overflow flag when a push is dropped.
module kb_event_fifo
    import kb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = EVT_W
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         push,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] rd_data,
    output logic         overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, pop_ok, push_ok;

    assign full    = (count == FULL_CNT);
    assign valid   = (count != '0);
    assign pop_ok  = pop && valid;
    // A pop in the same cycle frees the slot the push needs
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && !push_ok) overflow <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/kb_lock_controller.sv
// Scancode prefix parser with Caps/Num/Scroll lock tracking; decoded key
// events are queued for a downstream consumer.
module kb_lock_controller
    import kb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_keycode,
    input  logic       i_ready,
    output logic [2:0] o_led_status,
    output logic       o_event_valid,
    input  logic       i_event_ack,
    output logic [7:0] o_event_code,
    output logic       o_event_ext,
    output logic       o_event_break,
    output logic       o_overflow
);

    parse_state_t state_q, state_d;
    logic [2:0]   skip_q, skip_d;
    logic [2:0]   led_q, led_d;
    logic [2:0]   held_q, held_d;
    logic [2:0]   lock;
    logic         emit, evt_ext, evt_brk;
    logic [EVT_W-1:0] head;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            skip_q  <= '0;
            led_q   <= '0;
            held_q  <= '0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            led_q   <= led_d;
            held_q  <= held_d;
        end
    end

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        led_d   = led_q;
        held_d  = held_q;
        emit    = 1'b0;
        evt_ext = 1'b0;
        evt_brk = 1'b0;
        lock    = 3'b000;

        if (i_ready) begin
            case (state_q)
                ST_IDLE: begin
                    if (i_keycode == SC_E0) begin
                        state_d = ST_GOT_E0;
                    end else if (i_keycode == SC_F0) begin
                        state_d = ST_GOT_F0;
                    end else if (i_keycode == SC_E1) begin
                        state_d = ST_SKIP_E1;
                        skip_d  = E1_SKIP_LEN;
                    end else if (!is_filtered(i_keycode)) begin
                        emit = 1'b1;
                    end
                end
                ST_GOT_E0: begin
                    if (i_keycode == SC_F0) begin
                        state_d = ST_GOT_E0F0;
                    end else begin
                        emit    = 1'b1;
                        evt_ext = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_GOT_F0: begin
                    emit    = 1'b1;
                    evt_brk = 1'b1;
                    state_d = ST_IDLE;
                end
                ST_GOT_E0F0: begin
                    emit    = 1'b1;
                    evt_ext = 1'b1;
                    evt_brk = 1'b1;
                    state_d = ST_IDLE;
                end
                ST_SKIP_E1: begin
                    if (skip_q <= 3'd1) begin
                        skip_d  = 3'd0;
                        state_d = ST_IDLE;
                    end else begin
                        skip_d = skip_q - 3'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Held flags stop typematic repeats from re-toggling a lock LED
        if (emit && !evt_ext) lock = lock_mask(i_keycode);
        if (evt_brk) begin
            held_d = held_q & ~lock;
        end else begin
            led_d  = led_q ^ (lock & ~held_q);
            held_d = held_q | lock;
        end
    end

    kb_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (EVT_W)
    ) u_fifo (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .push     (emit),
        .wr_data  ({i_keycode, evt_ext, evt_brk}),
        .pop      (i_event_ack),
        .valid    (o_event_valid),
        .rd_data  (head),
        .overflow (o_overflow)
    );

    assign o_led_status  = led_q;
    assign o_event_code  = head[9:2];
    assign o_event_ext   = head[1];
    assign o_event_break = head[0];

endmodule

// File: tb/tb_kb_lock_controller.sv
// Scoreboard bench for kb_lock_controller: byte-stream reference model feeds
// an expected-event queue that a negedge monitor drains.
module tb_kb_lock_controller;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } evt_t;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic [7:0] i_keycode = 8'h00;
    logic       i_ready = 1'b0;
    logic       i_event_ack = 1'b0;
    logic [2:0] o_led_status;
    logic       o_event_valid;
    logic [7:0] o_event_code;
    logic       o_event_ext;
    logic       o_event_break;
    logic       o_overflow;

    kb_lock_controller #(.FIFO_DEPTH(DEPTH)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_keycode     (i_keycode),
        .i_ready       (i_ready),
        .o_led_status  (o_led_status),
        .o_event_valid (o_event_valid),
        .i_event_ack   (i_event_ack),
        .o_event_code  (o_event_code),
        .o_event_ext   (o_event_ext),
        .o_event_break (o_event_break),
        .o_overflow    (o_overflow)
    );

    always #5 i_clk = ~i_clk;

    // Reference model state
    evt_t       exp_q[$];
    logic [7:0] m_pre[$];
    int         m_skip = 0;
    logic [2:0] m_led = 3'b000;
    logic [2:0] m_held = 3'b000;
    logic       m_ovf = 1'b0;
    bit         in_rst = 1'b1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int lock_idx(input logic [7:0] c);
        if (c == 8'h58) return 2;
        if (c == 8'h77) return 1;
        if (c == 8'h7E) return 0;
        return -1;
    endfunction

    function automatic bit filt(input logic [7:0] c);
        return (c == 8'h00) || (c == 8'hAA) || (c == 8'hEE) || (c == 8'hFA) ||
               (c >= 8'hFC);
    endfunction

    // Collects prefix bytes in a list; a non-prefix byte completes the key
    task automatic model_byte(input logic [7:0] b, output bit ev, output evt_t e);
        bit has_e0, has_f0;
        int li;
        ev = 0;
        e  = '0;
        if (m_skip > 0) begin
            m_skip--;
        end else if (b == 8'hE1 && m_pre.size() == 0) begin
            m_skip = 7;
        end else if ((b == 8'hE0 && m_pre.size() == 0) ||
                     (b == 8'hF0 && (m_pre.size() == 0 ||
                      (m_pre.size() == 1 && m_pre[0] == 8'hE0)))) begin
            m_pre.push_back(b);
        end else if (m_pre.size() == 0 && filt(b)) begin
            ev = 0;
        end else begin
            has_e0 = 0;
            has_f0 = 0;
            foreach (m_pre[i]) begin
                if (m_pre[i] == 8'hE0) has_e0 = 1;
                if (m_pre[i] == 8'hF0) has_f0 = 1;
            end
            m_pre.delete();
            ev = 1;
            e.code = b;
            e.ext = has_e0;
            e.brk = has_f0;
            li = has_e0 ? -1 : lock_idx(b);
            if (li >= 0) begin
                if (has_f0) begin
                    m_held[li] = 1'b0;
                end else begin
                    if (!m_held[li]) m_led[li] = ~m_led[li];
                    m_held[li] = 1'b1;
                end
            end
        end
    endtask

    // Called at posedge+1; model updates land after the next posedge
    task automatic cycle(input logic rdy, input logic [7:0] b, input logic ack);
        int   occ;
        bit   pop_will, ev;
        evt_t e;
        i_ready     = rdy;
        i_keycode   = b;
        i_event_ack = ack;
        occ      = exp_q.size();
        pop_will = ack && (occ > 0);
        @(posedge i_clk);
        if (rdy) begin
            model_byte(b, ev, e);
            if (ev) begin
                if (occ < DEPTH || pop_will) exp_q.push_back(e);
                else m_ovf = 1'b1;
            end
        end
        #1;
        i_ready     = 1'b0;
        i_event_ack = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        cycle(1'b1, b, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_led"},   32'(o_led_status),  0);
        chk({tag, "_valid"}, 32'(o_event_valid), 0);
        chk({tag, "_code"},  32'(o_event_code),  0);
        chk({tag, "_ext"},   32'(o_event_ext),   0);
        chk({tag, "_brk"},   32'(o_event_break), 0);
        chk({tag, "_ovf"},   32'(o_overflow),    0);
    endtask

    // Entered at posedge+1; asserts reset mid-cycle, away from both edges
    task automatic do_reset();
        in_rst      = 1'b1;
        i_ready     = 1'b0;
        i_event_ack = 1'b0;
        #2;
        i_rst_n = 1'b0;
        #1;
        chk_zero("rst_async");
        @(posedge i_clk);
        #1;
        chk_zero("rst_held");
        exp_q.delete();
        m_pre.delete();
        m_skip = 0;
        m_led  = 3'b000;
        m_held = 3'b000;
        m_ovf  = 1'b0;
        #2;
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        in_rst = 1'b0;
    endtask

    always @(negedge i_clk) begin
        evt_t e;
        if (!in_rst) begin
            chk("led",      32'(o_led_status),  32'(m_led));
            chk("overflow", 32'(o_overflow),    32'(m_ovf));
            chk("valid",    32'(o_event_valid), 32'(exp_q.size() != 0));
            if (o_event_valid && i_event_ack && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("evt_code",  32'(o_event_code),  32'(e.code));
                chk("evt_ext",   32'(o_event_ext),   32'(e.ext));
                chk("evt_break", 32'(o_event_break), 32'(e.brk));
            end
        end
    end

    initial begin
        logic [7:0] b;
        logic [7:0] filt_tab [4];
        filt_tab = '{8'hAA, 8'hFA, 8'hFE, 8'h00};

        #1;
        do_reset();

        // Plain make/break
        send(8'h1C); send(8'hF0); send(8'h1C);
        drain(4);

        // Caps with typematic repeats
        send(8'h58); send(8'h58); send(8'h58); send(8'hF0); send(8'h58);
        drain(5);
        send(8'h58);
        drain(3);

        // Pause sequence swallowed, then Num toggles
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        drain(2);
        send(8'h77);
        drain(3);
        send(8'hF0); send(8'h77);
        drain(3);

        // Extended make/break; E0 7E must not touch Scroll
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        drain(4);
        send(8'hE0); send(8'h7E);
        drain(3);
        send(8'hE0); send(8'hF0); send(8'h7E);
        drain(3);

        // Overflow at depth 4, then push+pop on a full FIFO
        for (int i = 0; i < 5; i++) send(8'h11 + 8'(i));
        cycle(1'b1, 8'h21, 1'b1);
        drain(6);

        // Reset mid-prefix discards the pending E0
        send(8'hE0);
        do_reset();
        send(8'h1C);
        drain(3);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            case ($urandom_range(0, 9))
                0: b = 8'hE0;
                1: b = 8'hF0;
                2: b = ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'hF0;
                3: b = 8'h58;
                4: b = 8'h77;
                5: b = 8'h7E;
                6: b = filt_tab[$urandom_range(0, 3)];
                default: b = 8'($urandom_range(0, 255));
            endcase
            cycle(1'($urandom_range(0, 1)), b, 1'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 299) == 0) do_reset();
        end

        drain(DEPTH + 4);
        chk("drain_empty", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/kb_lock_controller.md
KB_LOCK_CONTROLLER -- requirements
Module: kb_lock_controller

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, giving the event FIFO depth; power of two, 2..16.
REQ-002 SHALL have port i_clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port i_keycode  input  8  received scancode byte from kb_interface.
REQ-005 SHALL have port i_ready  input  1  one-cycle strobe; i_keycode valid this cycle.
REQ-006 SHALL have port o_led_status  output  3  lock state to kb_interface: bit0 Scroll, bit1 Num, bit2 Caps.
REQ-007 SHALL have port o_event_valid  output  1  FIFO non-empty; head event presented.
REQ-008 SHALL have port i_event_ack  input  1  consumer pops head when asserted with o_event_valid.
REQ-009 SHALL have port o_event_code  output  8  head event base scancode.
REQ-010 SHALL have port o_event_ext  output  1  head event carried E0 prefix.
REQ-011 SHALL have port o_event_break  output  1  head event is a release (F0 prefix).
REQ-012 SHALL have port o_overflow  output  1  sticky: an event was dropped on full FIFO.

Function
REQ-013 SHALL act only on cycles with i_ready=1; i_keycode ignored otherwise.
REQ-014 SHALL run a prefix parser with states IDLE, GOT_E0, GOT_F0, GOT_E0F0, SKIP_E1.
REQ-015 IDLE: E0 -> GOT_E0; F0 -> GOT_F0; E1 -> SKIP_E1 with skip counter 7; filtered code (00,AA,EE,FA,FC,FD,FE,FF) -> discard, stay; other -> emit make, ext=0.
REQ-016 GOT_E0: F0 -> GOT_E0F0; other -> emit make, ext=1, IDLE.
REQ-017 GOT_F0: any -> emit break, ext=0, IDLE; GOT_E0F0: any -> emit break, ext=1, IDLE.
REQ-018 SKIP_E1: discard byte, decrement counter; return IDLE after 7th byte; no events, no lock changes (Pause sequence).
REQ-019 Lock keys (ext=0 only): 58 Caps -> bit2, 77 Num -> bit1, 7E Scroll -> bit0.
REQ-020 Lock make SHALL toggle its LED bit only if its held flag is 0, then set held; lock break clears held (typematic repeats never re-toggle).
REQ-021 o_led_status and FIFO write SHALL update on the cycle after the i_ready cycle (1-cycle latency); lock toggles regardless of FIFO full.
REQ-022 Emitted event pushes {code, ext, break}; on full with no simultaneous pop -> drop, set o_overflow.
REQ-023 Push and pop in same cycle SHALL both succeed at any occupancy, including full.
REQ-024 Pop with o_event_valid=0 SHALL be ignored; head fields hold stable while valid and not popped.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.

Reset
REQ-026 i_rst_n low SHALL asynchronously force: parser IDLE, skip counter 0, held flags 0, FIFO empty, o_led_status=0, o_event_valid=0, o_event_code=0, o_event_ext=0, o_event_break=0, o_overflow=0.
REQ-027 Reset mid-prefix or mid-SKIP_E1 SHALL discard partial sequence; next byte parsed from IDLE.
REQ-028 o_overflow SHALL clear only by reset.

Structure
REQ-029 Package kb_pkg SHALL hold scancode constants (E0, E1, F0, 58, 77, 7E, filter list), parser state encoding, LED bit indices.
REQ-030 FIFO SHALL be sub-module kb_event_fifo (10-bit entries, FIFO_DEPTH parameter).

Verification
REQ-031 Bytes 1C, F0 1C -> events {1C,ext0,make}, {1C,ext0,break}; LEDs 000.
REQ-032 Bytes 58, 58, 58, F0 58, 58 -> LED bit2 1 after first 58, stays 1 through repeats, 0 after final 58.
REQ-033 Bytes E1 14 77 E1 F0 14 F0 77 -> no events, o_led_status unchanged; next 77 toggles bit1.
REQ-034 Bytes E0 75, E0 F0 75 -> {75,ext1,make}, {75,ext1,break}; E0 7E -> no Scroll toggle.
REQ-035 No ack, 5 makes at depth 4 -> 4 events kept in order, o_overflow=1; push+pop on full cycle -> both succeed, count stays 4.
REQ-036 Reset asserted after E0 -> next byte 1C emits ext=0 make; all outputs 0 during reset.
